// File: rtl/ddr_word_bridge.sv
// Bridges 32-bit CPU word accesses onto a 512-bit Wishbone DDR port through a one-line read buffer.
// Hits return combinationally; misses and writes stall the CPU with nak for one IDLE cycle, the BUS phase, then release in RESP.
module ddr_word_bridge #(
   parameter int          TIMEOUT  = 1024,
   parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [31:0]  addrBus,
   input  logic [31:0]  dataInBus,
   input  logic [3:0]   weBus,
   input  logic         stb,
   input  logic         inval,
   output logic [31:0]  dataOutBus,
   output logic         nak,
   output logic         err,
   output logic [31:0]  addrDDR,
   output logic [511:0] doutDDR,
   output logic [63:0]  dmDDR,
   input  logic [511:0] dinDDR,
   output logic         cycDDR,
   output logic         stbDDR,
   output logic         weDDR,
   input  logic         ackDDR
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic [3:0]      we_q, we_d;
   logic [511:0]    line_q, line_d;
   logic [25:0]     tag_q, tag_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            to_q, to_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic hit, start, timeout;

   assign hit     = (state_q == IDLE) && stb && (weBus == 4'h0) && valid_q
                    && (tag_q == addrBus[31:6]) && !inval;
   assign start   = (state_q == IDLE) && stb && !hit;
   assign timeout = (state_q == BUS) && !ackDDR && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= '0;
         line_q  <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         line_q  <= line_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUS;
         BUS:     if (ackDDR || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      line_d  = line_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      err_d   = err_q | timeout;
      to_d    = to_q;
      cnt_d   = (state_q == BUS) ? cnt_q + 1'b1 : '0;
      if (start) begin
         addr_d = addrBus;
         data_d = dataInBus;
         we_d   = weBus;
      end
      if (state_q == BUS) to_d = timeout;
      // Write-through, no-allocate: only an already-buffered line absorbs write bytes
      if (state_q == BUS && ackDDR) begin
         if (we_q == 4'h0) begin
            line_d  = dinDDR;
            tag_d   = addr_q[31:6];
            valid_d = 1'b1;
         end else if (valid_q && tag_q == addr_q[31:6]) begin
            for (int b = 0; b < 4; b++)
               if (we_q[b]) line_d[{addr_q[5:2], 2'(b), 3'b000} +: 8] = data_q[8*b +: 8];
         end
      end
      if (inval) valid_d = 1'b0;
   end

   always_comb begin
      cycDDR     = (state_q == BUS);
      stbDDR     = (state_q == BUS);
      weDDR      = (state_q == BUS) && (we_q != 4'h0);
      addrDDR    = (state_q == BUS) ? {addr_q[31:6], 6'b0} : 32'h0;
      doutDDR    = weDDR ? {16{data_q}} : '0;
      dmDDR      = weDDR ? (64'(we_q) << {addr_q[5:2], 2'b00}) : 64'h0;
      nak        = rstn && (start || state_q == BUS);
      err        = err_q;
      dataOutBus = 32'h0;
      if (hit)
         dataOutBus = line_q[{addrBus[5:2], 5'b0} +: 32];
      else if (state_q == RESP && we_q == 4'h0)
         dataOutBus = to_q ? ERR_WORD : line_q[{addr_q[5:2], 5'b0} +: 32];
   end

endmodule

// File: tb/tb_ddr_word_bridge.sv
// Bench for ddr_word_bridge: directed vector table, reset corner sequence, then random traffic vs a line-buffer model.
module tb_ddr_word_bridge;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic [31:0]  addrBus, dataInBus, dataOutBus, addrDDR;
   logic [3:0]   weBus;
   logic         stb, inval, nak, err, cycDDR, stbDDR, weDDR, ackDDR;
   logic [511:0] doutDDR, dinDDR;
   logic [63:0]  dmDDR;

   ddr_word_bridge #(.TIMEOUT(TO), .ERR_WORD(32'hDEADBEEF)) dut (
      .clk(clk), .rstn(rstn), .addrBus(addrBus), .dataInBus(dataInBus), .weBus(weBus),
      .stb(stb), .inval(inval), .dataOutBus(dataOutBus), .nak(nak), .err(err),
      .addrDDR(addrDDR), .doutDDR(doutDDR), .dmDDR(dmDDR), .dinDDR(dinDDR),
      .cycDDR(cycDDR), .stbDDR(stbDDR), .weDDR(weDDR), .ackDDR(ackDDR)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // DDR backing store (word addressed) and the reference line buffer
   logic [31:0] ddr_mem [logic [29:0]];
   logic [31:0] m_buf [16];
   logic [25:0] m_tag;
   logic        m_valid;
   logic        m_err;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      int          dly;
      int          inv;
      int          exp_naks;
      logic [31:0] exp_dat;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] wa);
      if (ddr_mem.exists(wa)) return ddr_mem[wa];
      return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Issue one CPU request (caller is just after a rising edge); inv: 0 none, 1 with request, 2 with ack
   task automatic run_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          input int dly, input int inv, output int naks, output logic [31:0] got);
      logic        exp_hit, to, done, bad_bus;
      int          exp_naks, exp_bus, busn;
      logic [31:0] exp_dat, cur;
      logic [63:0] exp_dm;
      exp_hit  = (w == 4'h0) && m_valid && (m_tag == a[31:6]) && (inv != 1);
      to       = !exp_hit && (dly >= TO);
      exp_naks = exp_hit ? 0 : (to ? TO + 1 : dly + 2);
      exp_bus  = exp_hit ? 0 : (to ? TO : dly + 1);
      exp_dm   = 64'(w) << (4 * a[5:2]);
      if (w != 4'h0)    exp_dat = 32'h0;
      else if (exp_hit) exp_dat = m_buf[a[5:2]];
      else if (to)      exp_dat = 32'hDEADBEEF;
      else              exp_dat = mem_rd(a[31:2]);

      addrBus = a; weBus = w; dataInBus = d; stb = 1'b1; inval = (inv == 1);
      naks = 0; busn = 0; done = 1'b0; bad_bus = 1'b0; got = 32'h0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (nak) naks++;
         else begin done = 1'b1; got = dataOutBus; end
         @(posedge clk); #1;
         inval = 1'b0; ackDDR = 1'b0;
         if (done) stb = 1'b0;
         if (cycDDR) begin
            busn++;
            if (addrDDR !== {a[31:6], 6'b0} || stbDDR !== 1'b1 || weDDR !== (w != 4'h0) ||
                (w != 4'h0 && (dmDDR !== exp_dm || doutDDR !== {16{d}})))
               bad_bus = 1'b1;
            for (int k = 0; k < 16; k++) dinDDR[32*k +: 32] = mem_rd({addrDDR[31:6], 4'(k)});
            if (busn - 1 == dly) begin
               ackDDR = 1'b1;
               if (inv == 2) inval = 1'b1;
               for (int b = 0; b < 64; b++)
                  if (dmDDR[b]) begin
                     cur = mem_rd({addrDDR[31:6], 4'(b / 4)});
                     cur[8*(b%4) +: 8] = doutDDR[8*b +: 8];
                     ddr_mem[{addrDDR[31:6], 4'(b / 4)}] = cur;
                  end
            end
         end
      end
      chk("resp_seen", 64'(done), 64'd1);
      chk("nak_cycles", 64'(naks), 64'(exp_naks));
      chk("bus_cycles", 64'(busn), 64'(exp_bus));
      chk("bus_signals_bad", 64'(bad_bus), 64'd0);
      chk("rd_data", 64'(got), 64'(exp_dat));

      if (!exp_hit) begin
         if (inv == 1) m_valid = 1'b0;
         if (to) m_err = 1'b1;
         else begin
            if (w == 4'h0) begin
               for (int k = 0; k < 16; k++) m_buf[k] = mem_rd({a[31:6], 4'(k)});
               m_tag = a[31:6]; m_valid = 1'b1;
            end else if (m_valid && m_tag == a[31:6]) begin
               m_buf[a[5:2]] = mem_rd(a[31:2]);
            end
            if (inv == 2) m_valid = 1'b0;
         end
      end
      #1;
      chk("err_flag", 64'(err), 64'(m_err));
      chk("idle_dout", 64'(dataOutBus), 64'h0);
      chk("idle_nak", 64'(nak), 64'h0);
   endtask

   int          n;
   logic [31:0] g;
   logic [31:0] lines [4];

   initial begin
      ddr_mem[30'h411] = 32'h12345678;
      m_valid = 1'b0; m_err = 1'b0; m_tag = '0;
      for (int k = 0; k < 16; k++) m_buf[k] = 32'h0;

      tbl[0]  = '{32'h0000_1044, 4'h0, 32'h0,         3, 0, 5, 32'h1234_5678};
      tbl[1]  = '{32'h0000_1048, 4'h0, 32'h0,         0, 0, 0, mem_rd(30'h412)};
      tbl[2]  = '{32'h0000_1046, 4'h4, 32'h00AB_0000, 1, 0, 3, 32'h0};
      tbl[3]  = '{32'h0000_1044, 4'h0, 32'h0,         0, 0, 0, 32'h12AB_5678};
      tbl[4]  = '{32'h0000_1044, 4'h0, 32'h0,         0, 1, 2, 32'h12AB_5678};
      tbl[5]  = '{32'h0000_2000, 4'h0, 32'h0,        99, 0, 9, 32'hDEAD_BEEF};
      tbl[6]  = '{32'h0000_3008, 4'h0, 32'h0,         2, 2, 4, mem_rd(30'hC02)};
      tbl[7]  = '{32'h0000_3008, 4'h0, 32'h0,         0, 0, 2, mem_rd(30'hC02)};
      tbl[8]  = '{32'h0000_300C, 4'hF, 32'hCAFE_F00D, 0, 0, 2, 32'h0};
      tbl[9]  = '{32'h0000_300C, 4'h0, 32'h0,         0, 0, 0, 32'hCAFE_F00D};
      tbl[10] = '{32'h0000_1044, 4'hF, 32'h1111_2222, 0, 0, 2, 32'h0};
      tbl[11] = '{32'h0000_1044, 4'h0, 32'h0,         1, 0, 3, 32'h1111_2222};

      rstn = 1'b0; stb = 1'b1; inval = 1'b0; ackDDR = 1'b0; weBus = 4'h0;
      addrBus = 32'h0000_1044; dataInBus = 32'h0; dinDDR = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_nak", 64'(nak), 64'h0);
      chk("rst_cyc", 64'({cycDDR, stbDDR, weDDR}), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_addrddr", 64'(addrDDR), 64'h0);
      chk("rst_dm", dmDDR, 64'h0);
      chk("rst_dout_zero", 64'(doutDDR == '0), 64'h1);
      rstn = 1'b1; stb = 1'b0;
      @(negedge clk);
      chk("idle_nostb_nak", 64'(nak), 64'h0);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_req(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].dly, tbl[i].inv, n, g);
         chk($sformatf("tbl%0d_naks", i), 64'(n), 64'(tbl[i].exp_naks));
         chk($sformatf("tbl%0d_data", i), 64'(g), 64'(tbl[i].exp_dat));
      end

      // Reset during BUS followed by a late ack
      addrBus = 32'h0000_5000; weBus = 4'h0; stb = 1'b1;
      @(posedge clk); #1;
      chk("mid_bus_cyc", 64'(cycDDR), 64'h1);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_bus_cyc", 64'(cycDDR), 64'h0);
      chk("rst_bus_nak", 64'(nak), 64'h0);
      rstn = 1'b1; stb = 1'b0; ackDDR = 1'b1;
      @(posedge clk); #1;
      ackDDR = 1'b0;
      @(negedge clk);
      chk("late_ack_cyc", 64'(cycDDR), 64'h0);
      chk("late_ack_err", 64'(err), 64'h0);
      m_valid = 1'b0; m_err = 1'b0;
      @(posedge clk); #1;
      run_req(32'h0000_5000, 4'h0, 32'h0, 0, 0, n, g);
      chk("post_rst_miss", 64'(n), 64'd2);

      lines[0] = 32'h0000_1040; lines[1] = 32'h0000_3000;
      lines[2] = 32'h0000_7FC0; lines[3] = 32'hFFFF_FFC0;
      for (int i = 0; i < 80; i++) begin
         logic [31:0] ra;
         logic [3:0]  rw;
         int          rd, ri;
         ra = lines[$urandom_range(0, 3)] | ($urandom & 32'h3F);
         rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         rd = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 5);
         ri = $urandom_range(0, 9);
         ri = (ri == 0) ? 1 : ((ri == 1) ? 2 : 0);
         run_req(ra, rw, $urandom, rd, ri, n, g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
